// File: rtl/gc_pkg.sv
// Shared helpers for the N-bit Gray-code counter family: width bound,
// Gray<->binary conversion functions, the up-terminal Gray constant helper
// and the per-edge operation encoding.
package gc_pkg;

  // Widest counter supported by the helpers below.
  localparam int GC_MAX_LENGTH = 16;

  // All helpers work on a full-width word.
  // A narrower value is zero-extended before use.
  typedef logic [GC_MAX_LENGTH-1:0] gc_word_t;

  // Operation selected on a clock edge, in priority order.
  typedef enum logic [1:0] {
    GC_OP_HOLD = 2'd0,
    GC_OP_STEP = 2'd1,
    GC_OP_INIT = 2'd2,
    GC_OP_SRST = 2'd3
  } gc_op_e;

  // Binary to Gray.
  // Zero-extension keeps the result valid for any width up to the maximum.
  function automatic gc_word_t bin2gray(input gc_word_t x);
    return x ^ (x >> 1);
  endfunction

  // Gray to binary.
  // This is a prefix XOR taken from the MSB down. Leading zeros from
  // zero-extension do not change the result.
  function automatic gc_word_t gray2bin(input gc_word_t g);
    gc_word_t b;
    b = '0;
    b[GC_MAX_LENGTH-1] = g[GC_MAX_LENGTH-1];
    for (int i = GC_MAX_LENGTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Gray value of the all-ones binary count for a given width.
  // Only the MSB is set.
  function automatic gc_word_t gc_up_term_gray(input int width);
    gc_word_t t;
    t = '0;
    t[width-1] = 1'b1;
    return t;
  endfunction

endpackage

// File: rtl/gc_gray2bin.sv
// Combinational LENGTH-bit Gray-to-binary converter.
// Binary bit i is the XOR of all Gray bits at or above position i.
module gc_gray2bin #(
  parameter int LENGTH = 4
) (
  input  logic [LENGTH-1:0] gray,
  output logic [LENGTH-1:0] bin
);

  // Each binary bit is the XOR-reduction of the Gray word shifted down to it.
  always_comb begin
    bin = '0;
    for (int i = 0; i < LENGTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gc_nbit_updown_init_val.sv
// N-bit up/down Gray-code counter with synchronous clear-to-value,
// init-load, terminal-count, wrap pulse and cycle-active flag.
// Optional build macro: GC_NBIT_SATURATE_EN. When it is defined, steps
// saturate at the ends of the range instead of wrapping, and out_wrap
// never asserts.
// Legal LENGTH range is 2..16.
module gc_nbit_updown_init_val
  import gc_pkg::*;
#(
  parameter int LENGTH = 4
) (
  input  logic              clk,
  input  logic              in_ctr_Arst_n,
  input  logic              in_ctr_Srst,
  input  logic              in_ctr_en,
  input  logic              in_ctr_init,
  input  logic              in_ctr_dir,
  input  logic [LENGTH-1:0] in_val_Srst,
  input  logic [LENGTH-1:0] in_val_init,
  output logic [LENGTH-1:0] out_GC,
  output logic              out_tc,
  output logic              out_wrap,
  output logic              out_cycle
);

  localparam logic [LENGTH-1:0] BIN_ZERO     = {LENGTH{1'b0}};
  localparam logic [LENGTH-1:0] BIN_MAX      = {LENGTH{1'b1}};
  localparam logic [LENGTH-1:0] BIN_ONE      = {{(LENGTH-1){1'b0}}, 1'b1};
  localparam gc_word_t          UP_TERM_GRAY = gc_up_term_gray(LENGTH);

  logic [LENGTH-1:0] bin_r;
  logic [LENGTH-1:0] bin_next_s;
  logic [LENGTH-1:0] srst_bin_s;
  logic [LENGTH-1:0] init_bin_s;
  logic              wrap_next_s;
  logic              cycle_next_s;
  logic              tc_next_s;
  gc_op_e            op_s;
  gc_word_t          bin_ext_s;
  gc_word_t          gray_ext_s;

  gc_gray2bin #(.LENGTH(LENGTH)) u_srst_g2b (
    .gray (in_val_Srst),
    .bin  (srst_bin_s)
  );

  gc_gray2bin #(.LENGTH(LENGTH)) u_init_g2b (
    .gray (in_val_init),
    .bin  (init_bin_s)
  );

  // Select this edge's operation: clear beats init, init beats step.
  always_comb begin
    op_s = GC_OP_HOLD;
    if (in_ctr_Srst) begin
      op_s = GC_OP_SRST;
    end else if (in_ctr_init) begin
      op_s = GC_OP_INIT;
    end else if (in_ctr_en) begin
      op_s = GC_OP_STEP;
    end else begin
      op_s = GC_OP_HOLD;
    end
  end

  // Next binary count, wrap pulse and cycle flag for the selected operation.
  always_comb begin
    bin_next_s   = bin_r;
    wrap_next_s  = 1'b0;
    cycle_next_s = out_cycle;
    case (op_s)
      GC_OP_SRST: begin
        bin_next_s   = srst_bin_s;
        cycle_next_s = 1'b0;
      end
      GC_OP_INIT: begin
        bin_next_s   = init_bin_s;
        cycle_next_s = 1'b1;
      end
      GC_OP_STEP: begin
        if (in_ctr_dir) begin
          if (bin_r == BIN_MAX) begin
`ifdef GC_NBIT_SATURATE_EN
            bin_next_s  = bin_r;
`else
            bin_next_s  = BIN_ZERO;
            wrap_next_s = 1'b1;
`endif
          end else begin
            bin_next_s = bin_r + BIN_ONE;
          end
        end else begin
          if (bin_r == BIN_ZERO) begin
`ifdef GC_NBIT_SATURATE_EN
            bin_next_s  = bin_r;
`else
            bin_next_s  = BIN_MAX;
            wrap_next_s = 1'b1;
`endif
          end else begin
            bin_next_s = bin_r - BIN_ONE;
          end
        end
        // The cycle ends only when a step actually moves the count onto
        // zero. A saturated hold at zero does not end it.
        if ((bin_next_s == BIN_ZERO) && (bin_r != BIN_ZERO)) begin
          cycle_next_s = 1'b0;
        end else begin
          cycle_next_s = out_cycle;
        end
      end
      GC_OP_HOLD: begin
        bin_next_s = bin_r;
      end
      default: begin
        bin_next_s = bin_r;
      end
    endcase
  end

  // Gray image of the next count.
  // The terminal flag is computed from that count and the live direction.
  always_comb begin
    bin_ext_s                = '0;
    bin_ext_s[LENGTH-1:0]    = bin_next_s;
    gray_ext_s               = bin2gray(bin_ext_s);
    if (in_ctr_dir) begin
      tc_next_s = (gray_ext_s == UP_TERM_GRAY);
    end else begin
      tc_next_s = (bin_next_s == BIN_ZERO);
    end
  end

  // State and output registers.
  // out_GC is loaded directly from the next-count Gray image, so only one
  // bit of it changes on each step.
  always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
    if (!in_ctr_Arst_n) begin
      bin_r     <= BIN_ZERO;
      out_GC    <= BIN_ZERO;
      out_tc    <= 1'b0;
      out_wrap  <= 1'b0;
      out_cycle <= 1'b0;
    end else begin
      bin_r     <= bin_next_s;
      out_GC    <= gray_ext_s[LENGTH-1:0];
      out_tc    <= tc_next_s;
      out_wrap  <= wrap_next_s;
      out_cycle <= cycle_next_s;
    end
  end

endmodule

// File: tb/tb_gc_nbit_updown_init_val.sv
// Self-checking bench for gc_nbit_updown_init_val (LENGTH=4).
// An integer-arithmetic reference model is advanced on every active edge.
module tb_gc_nbit_updown_init_val;

  localparam int L = 4;
  localparam int M = 1 << L;
  localparam logic [L-1:0] UP_TBL [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                           4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  logic         clk;
  logic         rst_n;
  logic         srst;
  logic         init;
  logic         en;
  logic         dir;
  logic [L-1:0] vs;
  logic [L-1:0] vi;
  logic [L-1:0] out_gc;
  logic         out_tc;
  logic         out_wrap;
  logic         out_cycle;

  int n_tests;
  int n_fail;

  // Reference model state.
  int m_cnt;
  int m_cyc;
  int m_wrap;
  int m_tc;
  int m_stepped;

  gc_nbit_updown_init_val #(.LENGTH(L)) dut (
    .clk           (clk),
    .in_ctr_Arst_n (rst_n),
    .in_ctr_Srst   (srst),
    .in_ctr_en     (en),
    .in_ctr_init   (init),
    .in_ctr_dir    (dir),
    .in_val_Srst   (vs),
    .in_val_init   (vi),
    .out_GC        (out_gc),
    .out_tc        (out_tc),
    .out_wrap      (out_wrap),
    .out_cycle     (out_cycle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int from_gray(input int g);
    int b;
    b = g;
    for (int s = 1; s < L; s++) b = b ^ (g >> s);
    return b;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_cyc = 0; m_wrap = 0; m_tc = 0; m_stepped = 0;
  endtask

  // Advance the model by one edge using the inputs presented to the DUT.
  task automatic model_edge();
    int nxt;
    m_wrap    = 0;
    m_stepped = 0;
    if (srst) begin
      m_cnt = from_gray(int'(vs));
      m_cyc = 0;
    end else if (init) begin
      m_cnt = from_gray(int'(vi));
      m_cyc = 1;
    end else if (en) begin
      nxt = dir ? m_cnt + 1 : m_cnt - 1;
      if (nxt < 0 || nxt >= M) begin
`ifdef GC_NBIT_SATURATE_EN
        nxt = m_cnt;
`else
        m_wrap = 1;
        nxt = (nxt + M) % M;
`endif
      end
      m_stepped = (nxt != m_cnt);
      if (m_stepped != 0 && nxt == 0) m_cyc = 0;
      m_cnt = nxt;
    end
    m_tc = dir ? int'(m_cnt == M - 1) : int'(m_cnt == 0);
  endtask

  task automatic check_all();
    check_eq("gc", int'(out_gc), to_gray(m_cnt));
    check_eq("tc", int'(out_tc), m_tc);
    check_eq("wrap", int'(out_wrap), m_wrap);
    check_eq("cycle", int'(out_cycle), m_cyc);
  endtask

  // Drive one cycle of inputs, clock, update model, check outputs.
  task automatic cyc(input logic s, input logic i, input logic e, input logic d,
                     input logic [L-1:0] a, input logic [L-1:0] b);
    logic [L-1:0] prev;
    @(negedge clk);
    srst = s; init = i; en = e; dir = d; vs = a; vi = b;
    prev = out_gc;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (m_stepped != 0 && !s && !i) check_eq("onebit", $countones(out_gc ^ prev), 1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; srst = 1'b0; init = 1'b0; en = 1'b0; dir = 1'b0;
    vs = 4'h0; vi = 4'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_gc", int'(out_gc), 0);
    check_eq("rst_flags", int'({out_tc, out_wrap, out_cycle}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Up-count through the whole Gray sequence, then wrap.
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
      if (k < 16) check_eq("up_tbl", int'(out_gc), int'(UP_TBL[k]));
      if (k == 15) check_eq("up_tc", int'(out_tc), 1);
`ifndef GC_NBIT_SATURATE_EN
      if (k == 16) check_eq("up_wrap", int'(out_wrap), 1);
`endif
    end

    // Down-count from the current value, across zero.
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);

    // Init wins over simultaneous enable; then count up until cycle drops.
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h6);
    check_eq("init_gc", int'(out_gc), 6);
    check_eq("init_cycle", int'(out_cycle), 1);
    for (int k = 0; k < 20; k++) begin
      if (out_cycle) cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
    end
    check_eq("cycle_done", int'(out_cycle), 0);

    // Clear beats init.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h5);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'h3, 4'h6);
    check_eq("srst_gc", int'(out_gc), 3);
    check_eq("srst_cycle", int'(out_cycle), 0);

    // Asynchronous reset mid-count.
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("arst_gc", int'(out_gc), 0);
    check_eq("arst_flags", int'({out_tc, out_wrap, out_cycle}), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Alternating enable with direction flipping every 3 cycles.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h1);
    for (int k = 0; k < 24; k++) begin
      logic e;
      logic d;
      e = ((k % 2) == 0);
      d = (((k / 3) % 2) == 0);
      cyc(1'b0, 1'b0, e, d, 4'h0, 4'h0);
    end

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      logic s;
      logic i;
      logic e;
      logic d;
      logic [L-1:0] a;
      logic [L-1:0] b;
      s = ($urandom_range(0, 99) < 3);
      i = ($urandom_range(0, 99) < 6);
      e = ($urandom_range(0, 99) < 75);
      d = ($urandom_range(0, 99) < 50);
      a = L'($urandom_range(0, M - 1));
      b = L'($urandom_range(0, M - 1));
      cyc(s, i, e, d, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
